// File: rtl/booth16_mult_ctrl.sv
// booth16_mult_ctrl
// Sequential radix-16 Booth multiplier controller for the MIPS multiplier unit.
// One overlapping 5-bit window of the multiplier is consumed per clock, most
// significant digit first. Each digit is recoded to {sign, magnitude 0..8}, the
// signed multiple of the multiplicand is formed, and the result is accumulated
// into a 2*WIDTH product that drives HI/LO for MULT/MULTU.
//
// Build option: define BOOTH16_SKIP_LEAD_EN to start the digit walk at the
// highest nonzero digit. This shortens latency, and the products are unchanged.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      request pulse, sampled only in IDLE
//   is_signed  1 = MULT (two's complement), 0 = MULTU, sampled with start
//   a          multiplicand, sampled with start
//   b          multiplier, sampled with start
//   busy       high while digits are being accumulated
//   done       one-cycle pulse when hi/lo become valid
//   hi         product[2*WIDTH-1:WIDTH]
//   lo         product[WIDTH-1:0]
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on the accepting edge
// S_RUN  | one digit accumulated per cycle, cnt counts down to 0
// S_DONE | hi/lo valid, done pulsed, start ignored
module booth16_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ND   = (WIDTH + 4) / 4;
    localparam int EXTW = 4 * ND;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mx_q;
    logic [EXTW:0]   bz_q;     // extended multiplier with the implicit Bx[-1]=0 at bit 0
    logic [PW-1:0]   acc_q;
    logic [CNTW-1:0] cnt_q;

    // Multiplicand is kept at product width so that the partial product wraps
    // modulo 2^(2*WIDTH) without a separate extension step.
    logic [PW-1:0]   mx_in;
    logic [EXTW:0]   bz_in;

    assign mx_in = is_signed ? {{(PW-WIDTH){a[WIDTH-1]}}, a}
                             : {{(PW-WIDTH){1'b0}}, a};
    assign bz_in = is_signed ? {{(EXTW-WIDTH){b[WIDTH-1]}}, b, 1'b0}
                             : {{(EXTW-WIDTH){1'b0}}, b, 1'b0};

    logic [4:0]    win;
    logic [4:0]    dig;      // two's complement digit in -8..8
    logic          neg;
    logic [3:0]    mag;
    logic [PW-1:0] pp_mag;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc_next;

    // Window for digit cnt sits at bit 4*cnt of the zero-appended multiplier.
    assign win = 5'(bz_q >> {cnt_q, 2'b00});

    // d = -8*w4 + 4*w3 + 2*w2 + w1 + w0, i.e. signed(w[4:1]) + w[0].
    // 11111 sums to 0, so its sign comes out clear without a special case.
    assign dig      = {win[4], win[4:1]} + {4'b0000, win[0]};
    assign neg      = dig[4];
    assign mag      = neg ? 4'(5'd0 - dig) : dig[3:0];
    assign pp_mag   = {{(PW-4){1'b0}}, mag} * mx_q;
    assign pp       = neg ? (PW'(0) - pp_mag) : pp_mag;
    assign acc_next = {acc_q[PW-5:0], 4'b0000} + pp;

    logic            lead_any;
    logic [CNTW-1:0] lead_idx;

`ifdef BOOTH16_SKIP_LEAD_EN
    logic [4:0] lead_win;

    // The accumulator starts at zero, so digits above the highest nonzero one
    // contribute nothing and can be skipped.
    always_comb begin
        lead_any = 1'b0;
        lead_idx = '0;
        lead_win = '0;
        for (int i = 0; i < ND; i++) begin
            lead_win = 5'(bz_in >> (4 * i));
            if (lead_win != 5'b00000 && lead_win != 5'b11111) begin
                lead_any = 1'b1;
                lead_idx = CNTW'(i);
            end
        end
    end
`else
    assign lead_any = 1'b1;
    assign lead_idx = CNTW'(ND - 1);
`endif

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = lead_any ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            mx_q    <= '0;
            bz_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mx_q  <= mx_in;
                        bz_q  <= bz_in;
                        acc_q <= '0;
                        cnt_q <= lead_idx;
                        if (!lead_any) begin
                            hi <= '0;
                            lo <= '0;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_next;
                    if (cnt_q == '0) begin
                        hi <= acc_next[PW-1:WIDTH];
                        lo <= acc_next[WIDTH-1:0];
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth16_mult_ctrl.sv
module tb_booth16_mult_ctrl;

    localparam int ND = 9;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    booth16_mult_ctrl #(.WIDTH(32), .CNTW(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
        longint px;
        longint py;
        logic [63:0] ux;
        logic [63:0] uy;
        px = longint'($signed(x));
        py = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        if (s) return 64'(px * py);
        return ux * uy;
    endfunction

    // Rising edges from the accepting edge to the edge that makes done visible.
    function automatic int ref_lat(input logic s, input logic [31:0] y);
`ifdef BOOTH16_SKIP_LEAD_EN
        logic [36:0] ext;
        logic [4:0]  w;
        int          top;
        ext = {(s ? {4{y[31]}} : 4'b0000), y, 1'b0};
        top = -1;
        for (int i = 0; i < ND; i++) begin
            w = 5'(ext >> (4 * i));
            if (w != 5'd0 && w != 5'd31) top = i;
        end
        return top + 1;
`else
        return ND + 0 * int'(s) + 0 * int'(y[0]);
`endif
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int   edges;
        logic busy_ok;
        logic got;
        @(negedge clk);
        start = 1'b1; is_signed = s; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
        edges = 0; busy_ok = 1'b1; got = 1'b0;
        while (edges < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
        end
        if (!got) begin
            chk({tag, "_timeout"}, 64'(done), 64'd1);
            return;
        end
        chk({tag, "_lat"}, 64'(edges), 64'(ref_lat(s, y)));
        chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        int          ndone;
        int          first_k;
        int          second_k;
        logic [63:0] first_p;
        logic [63:0] second_p;
        logic [63:0] exp;
        logic        s;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] corner [4];
        logic        run_busy_ok;

        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;

        #3;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("u_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("s_ff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run_op("s_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("s_x0f", 1'b1, 32'h1234_5678, 32'h0000_000F, 64'h0000_0001_1111_1108);
        run_op("u5x6", 1'b0, 32'd5, 32'd6, 64'd30);
        run_op("u3x2", 1'b0, 32'd3, 32'd2, 64'd6);
        run_op("u_b0", 1'b0, 32'hDEAD_BEEF, 32'd0, 64'd0);
        run_op("s_bm1", 1'b1, 32'd12345, 32'hFFFF_FFFF, ref_prod(1'b1, 32'd12345, 32'hFFFF_FFFF));
        run_op("s_max", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        // Second start during RUN must be dropped without queuing.
        x = 32'd5; y = 32'h4000_0006;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd9;
        chk("ign_busy_at_start", 64'(busy), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; first_p = '0; run_busy_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) first_p = {hi, lo};
                ndone++;
            end else if (ndone == 0 && !busy) begin
                run_busy_ok = 1'b0;
            end
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_prod", first_p, ref_prod(1'b0, x, y));
        chk("ign_busy", 64'(run_busy_ok), 64'd1);

        // Asynchronous reset in the middle of a run aborts it.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        // Held start: back-to-back operations, one per IDLE cycle.
        x = 32'h0000_ABCD; y = 32'h8000_0001;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = x; b = y;
        @(posedge clk);
        ndone = 0; first_k = -1; second_k = -1; first_p = '0; second_p = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (ndone == 0) begin first_k = k; first_p = {hi, lo}; end
                else if (ndone == 1) begin second_k = k; second_p = {hi, lo}; start = 1'b0; end
                ndone++;
            end
        end
        start = 1'b0;
        exp = ref_prod(1'b0, x, y);
        chk("held_first_k", 64'(first_k), 64'(ref_lat(1'b0, y)));
        chk("held_second_k", 64'(second_k), 64'(2 * ref_lat(1'b0, y) + 2));
        chk("held_first_p", first_p, exp);
        chk("held_second_p", second_p, exp);
        repeat (30) @(negedge clk);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 4) == 0) y = y & 32'h0000_0FFF;
            run_op($sformatf("rnd%0d", i), s, x, y, ref_prod(s, x, y));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
